// File: rtl/mem_io_responder.sv
// Byte-wide memory-port responder: RAM with one-cycle registered reads, plus an I/O window
// (UART RX/TX FIFO, free-running cycle counter with snapshot, program-stop register).
module mem_io_responder #(
  parameter int RAM_AW = 17,
  parameter int TXQ_AW = 3
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ack,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int DEPTH = 1 << TXQ_AW;
  localparam logic [TXQ_AW:0] C_DEPTH = (TXQ_AW+1)'(DEPTH);
  localparam logic [TXQ_AW:0] C_HIGH  = (TXQ_AW+1)'(DEPTH - 1);
  localparam logic [TXQ_AW:0] C_ONE   = (TXQ_AW+1)'(1);

  logic [7:0]        r_ram [2**RAM_AW];
  logic [7:0]        r_txq [DEPTH];
  logic [TXQ_AW-1:0] r_wp;
  logic [TXQ_AW-1:0] r_rp;
  logic [TXQ_AW:0]   r_count;
  logic [31:0]       r_cnt;
  logic [31:0]       r_snap;
  logic              r_pend;
  logic [7:0]        r_din;
  logic              r_rx_ack;
  logic              r_done;
  logic              r_ovf;

  logic              w_io;
  logic [2:0]        w_off;
  logic [RAM_AW-1:0] w_ram_addr;
  logic              w_rd;
  logic              w_wr;
  logic              w_ram_wr;
  logic              w_cpu_push;
  logic              w_stop_wr;
  logic              w_space;
  logic              w_pop;
  logic              w_stop_req;
  logic              w_push_stop;
  logic              w_push_cpu;
  logic              w_push;
  logic [7:0]        w_push_byte;
  logic              w_rx_take;
  logic [7:0]        w_rd_byte;
  logic              w_unused;

  assign w_io       = (mem_a[17:16] == 2'b11);
  assign w_off      = mem_a[2:0];
  assign w_ram_addr = mem_a[RAM_AW-1:0];
  assign w_unused   = ^mem_a[31:18];

  assign w_rd       = rdy_in & ~mem_wr;
  assign w_wr       = rdy_in & mem_wr;
  assign w_ram_wr   = w_wr & ~w_io;
  assign w_cpu_push = w_wr & w_io & (w_off == 3'd0) & (mem_dout != 8'h00);
  assign w_stop_wr  = w_wr & w_io & (w_off == 3'd4);
  assign w_rx_take  = w_rd & w_io & (w_off == 3'd0) & rx_valid;

  // Space is judged on the registered count; a same-cycle pop does not open a slot.
  assign w_space     = (r_count < C_DEPTH);
  assign w_pop       = tx_valid & tx_ready;
  assign w_stop_req  = r_pend | w_stop_wr;
  assign w_push_stop = w_stop_req & w_space;
  assign w_push_cpu  = w_cpu_push & w_space & ~r_pend;
  assign w_push      = w_push_stop | w_push_cpu;
  assign w_push_byte = w_push_stop ? 8'h00 : mem_dout;

  always_comb begin
    w_rd_byte = 8'h00;
    if (!w_io) begin
      w_rd_byte = r_ram[w_ram_addr];
    end else begin
      case (w_off)
        3'd0:    w_rd_byte = rx_valid ? rx_data : 8'h00;
        3'd4:    w_rd_byte = r_cnt[7:0];
        3'd5:    w_rd_byte = r_snap[15:8];
        3'd6:    w_rd_byte = r_snap[23:16];
        3'd7:    w_rd_byte = r_snap[31:24];
        default: w_rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_ram_wr) r_ram[w_ram_addr] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_txq[r_wp] <= w_push_byte;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt    <= 32'd0;
      r_snap   <= 32'd0;
      r_din    <= 8'h00;
      r_rx_ack <= 1'b0;
    end else begin
      r_cnt    <= r_cnt + 32'd1;
      r_rx_ack <= w_rx_take;
      if (w_rd) r_din <= w_rd_byte;
      if (w_rd && w_io && (w_off == 3'd4)) r_snap <= r_cnt;
    end
  end

  // TX FIFO pointers, fill level and the sticky status flags
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_pend  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      r_pend <= w_stop_req & ~w_space;
      if (w_stop_wr) r_done <= 1'b1;
      if (w_cpu_push && !w_push_cpu) r_ovf <= 1'b1;
    end
  end

  assign mem_din        = r_din;
  assign rx_ack         = r_rx_ack;
  assign program_done   = r_done;
  assign tx_overflow    = r_ovf;
  assign tx_valid       = (r_count != '0);
  assign tx_data        = r_txq[r_rp];
  assign io_buffer_full = (r_count >= C_HIGH);

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_mem_io_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_a = 32'h0;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_wr = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        rx_ack;
  logic        program_done;
  logic        tx_overflow;

  int n_chk = 0;
  int n_err = 0;

  mem_io_responder #(.RAM_AW(17), .TXQ_AW(3)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .program_done(program_done), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_ram [int];
  logic [7:0]  m_q [$];
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_snap = 32'd0;
  logic [7:0]  m_din = 8'h00;
  logic        m_ack = 1'b0;
  logic        m_done = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0; m_snap = 0; m_din = 0; m_ack = 0;
    m_done = 0; m_ovf = 0; m_pend = 0;
  endtask

  task automatic model_step();
    logic io, cpu, stp, pop, space, push_stop, pend_old;
    logic [2:0] off;
    int a;
    io = (mem_a[17:16] == 2'b11);
    off = mem_a[2:0];
    a = int'(mem_a[16:0]);
    pop = (m_q.size() != 0) && tx_ready;
    space = (m_q.size() < DEPTH);
    cpu = 0; stp = 0; m_ack = 0;
    if (rdy_in) begin
      if (mem_wr) begin
        if (!io) m_ram[a] = mem_dout;
        else if (off == 3'd0 && mem_dout != 8'h00) cpu = 1;
        else if (off == 3'd4) stp = 1;
      end else if (!io) begin
        m_din = m_ram.exists(a) ? m_ram[a] : 8'h00;
      end else begin
        case (off)
          3'd0: begin
            if (rx_valid) begin m_din = rx_data; m_ack = 1; end
            else m_din = 8'h00;
          end
          3'd4: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
          3'd5: m_din = m_snap[15:8];
          3'd6: m_din = m_snap[23:16];
          3'd7: m_din = m_snap[31:24];
          default: m_din = 8'h00;
        endcase
      end
    end
    if (stp) m_done = 1;
    pend_old = m_pend;
    push_stop = (m_pend || stp) && space;
    m_pend = (m_pend || stp) && !space;
    if (pop) void'(m_q.pop_front());
    if (push_stop) m_q.push_back(8'h00);
    if (cpu) begin
      if (space && !pend_old) m_q.push_back(mem_dout);
      else m_ovf = 1;
    end
    m_cnt = m_cnt + 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("mem_din", mem_din, m_din);
    chk("tx_valid", tx_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
    chk("io_buffer_full", io_buffer_full, m_q.size() >= DEPTH - 1);
    chk("rx_ack", rx_ack, m_ack);
    chk("program_done", program_done, m_done);
    chk("tx_overflow", tx_overflow, m_ovf);
  end

  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    @(negedge clk);
    mem_a = a; mem_wr = wr; mem_dout = d; rdy_in = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rdy_in = 1'b0; mem_wr = 1'b0;
  endtask

  logic [7:0] stop_exp [9] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h00};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_buf_full", io_buffer_full, 1'b0);
    chk("rst_rx_ack", rx_ack, 1'b0);
    chk("rst_done", program_done, 1'b0);
    chk("rst_ovf", tx_overflow, 1'b0);
    rst_n = 1'b1;

    // Counter snapshot: read lands on the 101st edge after release
    repeat (99) @(negedge clk);
    bus(32'h30004, 1'b0, 8'h00);
    bus(32'h30005, 1'b0, 8'h00);
    chk("snap_b0", mem_din, 8'h64);
    bus(32'h30006, 1'b0, 8'h00);
    chk("snap_b1", mem_din, 8'h00);
    bus(32'h30007, 1'b0, 8'h00);
    chk("snap_b2", mem_din, 8'h00);
    idle();
    chk("snap_b3", mem_din, 8'h00);

    // RAM round-trip
    bus(32'h00123, 1'b1, 8'hA5);
    bus(32'h00123, 1'b0, 8'h00);
    idle();
    chk("ram_123", mem_din, 8'hA5);
    bus(32'h00124, 1'b1, 8'h5A);
    bus(32'h00124, 1'b0, 8'h00);
    idle();
    chk("ram_124", mem_din, 8'h5A);
    bus(32'h00123, 1'b0, 8'h00);
    idle();
    chk("ram_123_again", mem_din, 8'hA5);

    // UART receive
    rx_valid = 1'b1; rx_data = 8'h3C;
    bus(32'h30000, 1'b0, 8'h00);
    idle();
    chk("rx_data", mem_din, 8'h3C);
    chk("rx_ack_pulse", rx_ack, 1'b1);
    idle();
    chk("rx_ack_clear", rx_ack, 1'b0);
    rx_valid = 1'b0;
    bus(32'h30000, 1'b0, 8'h00);
    idle();
    chk("rx_empty", mem_din, 8'h00);

    // UART output, zero byte suppressed
    tx_ready = 1'b1;
    bus(32'h30000, 1'b1, 8'h48);
    bus(32'h30000, 1'b1, 8'h00);
    chk("tx_H", tx_data, 8'h48);
    bus(32'h30000, 1'b1, 8'h69);
    chk("tx_zero_skipped", tx_valid, 1'b0);
    idle();
    chk("tx_i", tx_data, 8'h69);
    idle();
    chk("tx_drained", tx_valid, 1'b0);

    // Backpressure and overflow
    tx_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus(32'h30000, 1'b1, 8'(i));
      if (i == 7) chk("not_full_at_6", io_buffer_full, 1'b0);
      if (i == 8) chk("full_at_7", io_buffer_full, 1'b1);
    end
    idle();
    chk("overflow", tx_overflow, 1'b1);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("bp_valid", tx_valid, 1'b1);
      chk("bp_order", tx_data, 8'(k));
      @(negedge clk);
    end
    chk("bp_empty", tx_valid, 1'b0);

    // Stop with a full FIFO
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus(32'h30000, 1'b1, 8'h11 + 8'(i));
    bus(32'h30004, 1'b1, 8'hFF);
    idle();
    chk("stop_done", program_done, 1'b1);
    idle();
    idle();
    tx_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("stop_valid", tx_valid, 1'b1);
      chk("stop_order", tx_data, stop_exp[k]);
      @(negedge clk);
    end
    chk("stop_empty", tx_valid, 1'b0);

    // Stalled write is ignored
    @(negedge clk);
    rdy_in = 1'b0; mem_wr = 1'b1; mem_a = 32'h30000; mem_dout = 8'h77;
    idle();
    idle();
    chk("stall_no_push", tx_valid, 1'b0);

    // Late snapshot across all bytes (model-checked)
    bus(32'h30004, 1'b0, 8'h00);
    bus(32'h30005, 1'b0, 8'h00);
    bus(32'h30006, 1'b0, 8'h00);
    bus(32'h30007, 1'b0, 8'h00);
    bus(32'h30001, 1'b0, 8'h00);
    idle();

    // Asynchronous reset mid-drain
    tx_ready = 1'b0;
    bus(32'h30000, 1'b1, 8'h21);
    bus(32'h30000, 1'b1, 8'h22);
    bus(32'h30000, 1'b1, 8'h23);
    idle();
    tx_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx_valid", tx_valid, 1'b0);
    chk("async_done", program_done, 1'b0);
    chk("async_ovf", tx_overflow, 1'b0);
    chk("async_buf_full", io_buffer_full, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus(32'h30004, 1'b0, 8'h00);
    idle();
    chk("cnt_restart", mem_din, 8'h01);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Bus-side responder for the CPU's byte-wide memory port. It serves RAM reads and writes with the fixed one-cycle read latency the core expects, and decodes the I/O window at `mem_a[17:16]==2'b11`. The I/O window covers the UART byte, the 32-bit cycle counter and the program-stop register. A transmit FIFO drives the UART, and its fill level feeds back to the core as `io_buffer_full`.

## Interface
Parameters:
- `RAM_AW`, 17: RAM byte-address width (128 KB).
- `TXQ_AW`, 3: transmit FIFO address width; depth = 2^TXQ_AW.

Ports:
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  reset; one clock, reset is asynchronous and active-low.
- `rdy_in`  in  1  bus-access enable; when low, bus accesses are ignored.
- `mem_a`  in  32  byte address from the core.
- `mem_dout`  in  8  write data from the core.
- `mem_wr`  in  1  1 = write, 0 = read.
- `mem_din`  out  8  read data to the core, registered.
- `io_buffer_full`  out  1  TX FIFO near-full.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  UART accepts the head byte when `tx_valid & tx_ready`.
- `rx_data`  in  8  UART received byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ack`  out  1  one-cycle pulse: byte consumed.
- `program_done`  out  1  sticky: stop register was written.
- `tx_overflow`  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- **Address decode.**
  - `io = (mem_a[17:16]==2'b11)`.
  - Otherwise the access targets RAM at `mem_a[RAM_AW-1:0]`.
  - I/O offset is `mem_a[2:0]`.
- **Access qualification.** An access is taken only in cycles with `rdy_in=1`. When `rdy_in=0`, RAM, FIFO push, `rx_ack`, snapshot and `mem_din` hold; the counter and the FIFO pop still run.
- **RAM.**
  - A write stores `mem_dout` at the clock edge.
  - A read registers `ram[addr]` into `mem_din`.
  - A same-address write followed by a read in the next cycle returns the new data.
- **I/O read.**
  - Offset 0: if `rx_valid`, `mem_din <= rx_data` and `rx_ack` pulses; otherwise `mem_din <= 0`.
  - Offset 4: `mem_din <= cnt[7:0]` and `snap <= cnt`.
  - Offsets 5, 6, 7: `snap[15:8]`, `snap[23:16]`, `snap[31:24]` (little-endian).
  - Other offsets: 0.
- **I/O write.**
  - Offset 0 with nonzero data: push to the FIFO. Data 0x00 is ignored.
  - Offset 4: set `program_done` and push 0x00 into the FIFO.
  - If the FIFO is full at push time, a pending-stop flag holds the 0x00 push until space exists. Stop is never dropped.
  - Other offsets: ignored.
- **Counter.** `cnt` is 32-bit, starts at 0 after reset release, increments every clock and wraps modulo 2^32.
- **TX FIFO.**
  - Circular buffer with read/write pointers and a `TXQ_AW+1`-bit count.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push while count = depth drops the byte and sets `tx_overflow` (the pending stop is the exception).
  - The pending-stop push has priority over a CPU push in the same cycle. The CPU byte is then treated as a full-FIFO push.
- **`io_buffer_full`** = count ≥ depth−1. The one-slot headroom covers the core's one-cycle reaction delay.

## Timing
- **Reset values.**
  - Outputs: `mem_din`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_data`=FIFO slot 0 (undefined contents), `rx_ack`=0, `program_done`=0, `tx_overflow`=0.
  - Internal: `cnt`=0, `snap`=0, pointers=0, pending-stop=0. RAM contents are not reset.
- **Reset mid-operation.** Asserting `rst_n_in` low clears all of the above immediately (asynchronous), including a pending stop.
- **Read latency.** Address presented in cycle N gives data on `mem_din` in cycle N+1. `mem_din` holds until the next read.
- **Write latency.** Write in cycle N is visible to a read issued in cycle N+1.
- **`rx_ack`** is high for exactly the cycle after the read edge, for one read.
- **`tx_valid`** rises the cycle after the first push. `tx_data` is the head combinationally from the registered read pointer.
- **`io_buffer_full`** is combinational from the registered count, so it updates the cycle after a push or pop.

## Test plan
- **RAM round-trip.** Write 0xA5 to 0x00123, then read 0x00123 → `mem_din`=0xA5 one cycle later. Read 0x00124 after writing 0x5A there → 0x5A.
- **UART output.** Write 'H', 0x00, 'i' to 0x30000 with `tx_ready`=1 → `tx_data` sequence 0x48, 0x69; the 0x00 never appears.
- **Backpressure.**
  - Setup: `tx_ready`=0, depth 8.
  - After 7 pushes, `io_buffer_full`=1.
  - Pushes 9 and 10 are dropped and `tx_overflow`=1.
  - Raise `tx_ready` → exactly 8 bytes drain in order.
- **Counter snapshot.** 100 cycles after reset, read 0x30004..0x30007 on consecutive cycles → bytes of the count latched at the 0x30004 read (e.g. 0x64, 0, 0, 0), not the advancing count.
- **Stop with full FIFO.**
  - Setup: `tx_ready`=0, FIFO full, write 0x30004.
  - `program_done`=1 next cycle.
  - After one pop, 0x00 enters the FIFO and emerges last.
- **Reset and stall.** Assert `rst_n_in` low mid-drain → `tx_valid`=0 and `cnt`=0 asynchronously. With `rdy_in`=0, a write to 0x30000 is ignored and the FIFO is unchanged.
